hd_mux2_arb_stage: RTL and testbench

- Registered 2:1 merge stage. Arbitrates between two valid/ready source streams, A0 and A1, and steers the winner through a 2:1 data select.
- The winning beat is captured in an output register, together with the select value that produced it.
- Sits directly downstream of the HD 2:1 mux cell datapath. It generates the SL select for that datapath and registers its Z result, so the fault-sim netlist has a cycle-accurate consumer for mux outputs.

---
 rtl/hd_mux2_arb_stage_if.sv | 39 +++
 rtl/hd_mux2_arb_stage.sv | 82 ++++++++
 tb/tb_hd_mux2_arb_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hd_mux2_arb_stage_if.sv
// Handshake bundle for hd_mux2_arb_stage: two valid/ready sources, the mux select and the registered output.
// A0_LAST/A1_LAST exist only when HD_MUX2_ARB_LOCK_EN is defined.
interface hd_mux2_arb_stage_if #(
   parameter int WIDTH = 8
);
   logic             A0_VALID;
   logic [WIDTH-1:0] A0_DATA;
   logic             A0_READY;
   logic             A1_VALID;
   logic [WIDTH-1:0] A1_DATA;
   logic             A1_READY;
`ifdef HD_MUX2_ARB_LOCK_EN
   logic             A0_LAST;
   logic             A1_LAST;
`endif
   logic             SL;
   logic             Z_VALID;
   logic [WIDTH-1:0] Z_DATA;
   logic             Z_SL;
   logic             Z_READY;

   modport master (
      output A0_VALID, A0_DATA, A1_VALID, A1_DATA,
`ifdef HD_MUX2_ARB_LOCK_EN
      output A0_LAST, A1_LAST,
`endif
      output Z_READY,
      input  A0_READY, A1_READY, SL, Z_VALID, Z_DATA, Z_SL
   );

   modport slave (
      input  A0_VALID, A0_DATA, A1_VALID, A1_DATA,
`ifdef HD_MUX2_ARB_LOCK_EN
      input  A0_LAST, A1_LAST,
`endif
      input  Z_READY,
      output A0_READY, A1_READY, SL, Z_VALID, Z_DATA, Z_SL
   );
endinterface

// File: rtl/hd_mux2_arb_stage.sv
// Round-robin 2:1 merge into one output register; HD_MUX2_ARB_LOCK_EN adds packet locking on *_LAST.
// Latency: one cycle from accept to Z_VALID; full throughput while Z_READY stays high.
// Backpressure: a held, unaccepted output beat (Z_VALID && !Z_READY) drops both source READYs.
module hd_mux2_arb_stage #(
   parameter int WIDTH    = 8,
   parameter int A0_FIRST = 1
) (
   input logic              CK,
   input logic              RST,
   hd_mux2_arb_stage_if.slave bus
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;
   // PRI holds the last grant, so resetting it to 1 makes A0 win the first contention.
   localparam logic PRI_RST = (A0_FIRST != 0);

   logic [0:0]       state;
   logic             pri;
   logic [WIDTH-1:0] z_dat;
   logic             z_sl;
   logic             ld;
   logic             a0_req;
   logic             a1_req;
   logic             gnt_vld;
   logic             gnt;
   logic [WIDTH-1:0] sel_dat;

`ifdef HD_MUX2_ARB_LOCK_EN
   logic lk;
   // While locked, the locked source is always PRI; the other side is masked out.
   assign a0_req = bus.A0_VALID && !(lk && pri);
   assign a1_req = bus.A1_VALID && !(lk && !pri);
`else
   assign a0_req = bus.A0_VALID;
   assign a1_req = bus.A1_VALID;
`endif

   assign ld      = (state == EMPTY) || bus.Z_READY;
   assign gnt_vld = a0_req || a1_req;

   always_comb begin
      gnt = pri;
      if (a0_req && a1_req) gnt = !pri;
      else if (a0_req)      gnt = 1'b0;
      else if (a1_req)      gnt = 1'b1;
   end

   // Consensus term keeps bits the two sources agree on stable even if the select is unknown.
   assign sel_dat = (bus.A0_DATA & ~{WIDTH{gnt}}) | (bus.A1_DATA & {WIDTH{gnt}})
                  | (bus.A0_DATA & bus.A1_DATA);

   assign bus.SL       = gnt;
   assign bus.A0_READY = !RST && ld && gnt_vld && !gnt;
   assign bus.A1_READY = !RST && ld && gnt_vld && gnt;
   assign bus.Z_VALID  = (state == FULL);
   assign bus.Z_DATA   = z_dat;
   assign bus.Z_SL     = z_sl;

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state <= EMPTY;
         pri   <= PRI_RST;
         z_dat <= '0;
         z_sl  <= 1'b0;
`ifdef HD_MUX2_ARB_LOCK_EN
         lk    <= 1'b0;
`endif
      end else if (ld) begin
         if (gnt_vld) begin
            state <= FULL;
            z_dat <= sel_dat;
            z_sl  <= gnt;
            pri   <= gnt;
`ifdef HD_MUX2_ARB_LOCK_EN
            lk    <= gnt ? !bus.A1_LAST : !bus.A0_LAST;
`endif
         end else begin
            state <= EMPTY;
         end
      end
   end
endmodule

// File: tb/tb_hd_mux2_arb_stage.sv
// Directed bench for hd_mux2_arb_stage; define HD_MUX2_ARB_LOCK_EN to also exercise packet locking.
module tb_hd_mux2_arb_stage;
   logic CK;
   logic RST;
   int   checks;
   int   errors;

   hd_mux2_arb_stage_if #(.WIDTH(8)) bus ();

   hd_mux2_arb_stage #(.WIDTH(8), .A0_FIRST(1)) dut (
      .CK  (CK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   // Pulse reset between edges so the next edge is the first one after release.
   task automatic pulse_reset();
      RST = 1'b1;
      #1;
      RST = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST = 1'b1;
      bus.A0_VALID = 1'b0;
      bus.A0_DATA  = 8'h00;
      bus.A1_VALID = 1'b0;
      bus.A1_DATA  = 8'h00;
      bus.Z_READY  = 1'b1;
`ifdef HD_MUX2_ARB_LOCK_EN
      bus.A0_LAST  = 1'b0;
      bus.A1_LAST  = 1'b0;
`endif
      #2;
      chk("rst_zvld", bus.Z_VALID, 1'b0);
      chk("rst_zdat", bus.Z_DATA, 8'h00);
      chk("rst_zsl", bus.Z_SL, 1'b0);
      chk("rst_sl", bus.SL, 1'b1);
      tick();
      RST = 1'b0;
      tick();
      chk("idle_zvld", bus.Z_VALID, 1'b0);
      chk("idle_zdat", bus.Z_DATA, 8'h00);
      chk("idle_rdy0", bus.A0_READY, 1'b0);
      chk("idle_rdy1", bus.A1_READY, 1'b0);
      chk("idle_sl", bus.SL, 1'b1);

      // A0 alone, three back-to-back beats
      bus.A0_VALID = 1'b1;
      bus.A0_DATA  = 8'h3C;
      #1;
      chk("a0_sl", bus.SL, 1'b0);
      chk("a0_rdy0", bus.A0_READY, 1'b1);
      chk("a0_rdy1", bus.A1_READY, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("a0_zvld", bus.Z_VALID, 1'b1);
         chk("a0_zdat", bus.Z_DATA, 8'h3C);
         chk("a0_zsl", bus.Z_SL, 1'b0);
      end
      bus.A0_VALID = 1'b0;
      tick();
      chk("drain_zvld", bus.Z_VALID, 1'b0);
      chk("drain_zdat", bus.Z_DATA, 8'h3C);

      // Both contend continuously: A0 first, then alternate
      pulse_reset();
      bus.A0_VALID = 1'b1;
      bus.A0_DATA  = 8'hA0;
      bus.A1_VALID = 1'b1;
      bus.A1_DATA  = 8'hA1;
      #1;
      chk("rr_sl0", bus.SL, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_zdat", bus.Z_DATA, (i % 2 == 0) ? 8'hA0 : 8'hA1);
         chk("rr_zsl", bus.Z_SL, (i % 2 == 0) ? 1'b0 : 1'b1);
         chk("rr_sl", bus.SL, (i % 2 == 0) ? 1'b1 : 1'b0);
      end

      // Downstream stall after the first beat must freeze Z and PRI
      pulse_reset();
      tick();
      chk("st_first", bus.Z_DATA, 8'hA0);
      bus.Z_READY = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("st_rdy0", bus.A0_READY, 1'b0);
         chk("st_rdy1", bus.A1_READY, 1'b0);
         tick();
         chk("st_zdat", bus.Z_DATA, 8'hA0);
         chk("st_zvld", bus.Z_VALID, 1'b1);
         chk("st_sl", bus.SL, 1'b1);
      end
      bus.Z_READY = 1'b1;
      #1;
      chk("st_rel_rdy1", bus.A1_READY, 1'b1);
      tick();
      chk("st_rel_zdat", bus.Z_DATA, 8'hA1);
      chk("st_rel_zsl", bus.Z_SL, 1'b1);

      // Reset asserted while holding a beat
      bus.A1_VALID = 1'b0;
      bus.A0_DATA  = 8'h55;
      tick();
      chk("mr_zdat", bus.Z_DATA, 8'h55);
      chk("mr_zvld", bus.Z_VALID, 1'b1);
      bus.Z_READY = 1'b0;
      #2;
      RST = 1'b1;
      bus.Z_READY = 1'b1;
      #1;
      chk("mr_zvld0", bus.Z_VALID, 1'b0);
      chk("mr_zdat0", bus.Z_DATA, 8'h00);
      chk("mr_rdy0", bus.A0_READY, 1'b0);
      tick();
      RST = 1'b0;
      bus.A0_DATA  = 8'hA0;
      bus.A1_VALID = 1'b1;
      #1;
      chk("mr_sl", bus.SL, 1'b0);
      chk("mr_rdy0r", bus.A0_READY, 1'b1);
      tick();
      chk("mr_zdat1", bus.Z_DATA, 8'hA0);
      chk("mr_zsl1", bus.Z_SL, 1'b0);

`ifdef HD_MUX2_ARB_LOCK_EN
      // A1 three-beat packet holds off A0 until its LAST beat
      pulse_reset();
      bus.A1_VALID = 1'b0;
      bus.A0_DATA  = 8'h0F;
      bus.A0_LAST  = 1'b1;
      tick();
      chk("lk_pre_zsl", bus.Z_SL, 1'b0);
      bus.A1_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.A1_DATA = 8'h11 + 8'(i);
         bus.A1_LAST = (i == 2);
         #1;
         chk("lk_rdy0", bus.A0_READY, 1'b0);
         chk("lk_rdy1", bus.A1_READY, 1'b1);
         tick();
         chk("lk_zsl", bus.Z_SL, 1'b1);
         chk("lk_zdat", bus.Z_DATA, 8'h11 + 8'(i));
      end
      bus.A1_LAST = 1'b0;
      #1;
      chk("lk_post_rdy0", bus.A0_READY, 1'b1);
      tick();
      chk("lk_post_zsl", bus.Z_SL, 1'b0);
      chk("lk_post_zdat", bus.Z_DATA, 8'h0F);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
